rdi_rx_adapter: RTL and testbench



---
 rtl/adapter_pkg.sv | 16 +
 rtl/rx_credit_ctrl.sv | 58 +++++
 rtl/rdi_rx_adapter.sv | 142 ++++++++++++++
 tb/tb_rdi_rx_adapter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adapter_pkg.sv
// Shared adapter definitions: DLA word width, default receive buffer
// geometry and the receive-side state encoding.
package adapter_pkg;

  localparam int DLA_DATA_W   = 64;
  localparam int RX_DEPTH     = 16;
  localparam int RX_CRD_BATCH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_credit_ctrl.sv
// Credit return controller for the RDI receive adapter. Accumulates
// credited pops, decides when to return them as a batch (or as a
// flush when the buffer has emptied) and owns the lp_crd_* registers.
module rx_credit_ctrl
  import adapter_pkg::*;
#(
  parameter int DEPTH     = RX_DEPTH,
  parameter int CRD_BATCH = RX_CRD_BATCH,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  rx_state_e        state,
  input  logic             pop,
  input  logic             buf_empty,
  output logic             lp_crd_valid_o,
  output logic [CNT_W-1:0] lp_crd_cnt_o
);

  logic [CNT_W-1:0] crd_acc;
  logic             credit_pop;
  logic             do_return;

  // Only RUN pops earn credit; a return is held off while the previous
  // pulse is still on the wire so two pulses are never back to back.
  always_comb begin
    credit_pop = pop && (state == RUN);
    do_return  = (state == RUN) && !lp_crd_valid_o &&
                 ((crd_acc >= CNT_W'(CRD_BATCH)) ||
                  ((crd_acc != '0) && buf_empty));
  end

  // Accumulator and registered credit pulse; INIT advertises the whole buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crd_acc        <= '0;
      lp_crd_valid_o <= 1'b0;
      lp_crd_cnt_o   <= '0;
    end else begin
      lp_crd_valid_o <= 1'b0;
      lp_crd_cnt_o   <= '0;
      if (state == INIT) begin
        lp_crd_valid_o <= 1'b1;
        lp_crd_cnt_o   <= CNT_W'(DEPTH);
        crd_acc        <= '0;
      end else if (state == IDLE) begin
        crd_acc <= '0;
      end else if (do_return) begin
        lp_crd_valid_o <= 1'b1;
        lp_crd_cnt_o   <= crd_acc;
        crd_acc        <= credit_pop ? CNT_W'(1) : '0;
      end else if (credit_pop) begin
        crd_acc <= crd_acc + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rdi_rx_adapter.sv
// Receive-side RDI adapter: buffers words arriving on pl_data/pl_valid,
// hands them to the DLA under on/off flow control and returns consumed
// slots to the far-end transmitter as batched credits.
// Optional build macro RDI_RX_PARITY_EN adds an even-parity checker
// (pl_parity input, sticky parity_err_o output).
module rdi_rx_adapter
  import adapter_pkg::*;
#(
  parameter int DATA_W    = DLA_DATA_W,
  parameter int DEPTH     = RX_DEPTH,
  parameter int CRD_BATCH = RX_CRD_BATCH,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] pl_data,
  input  logic              pl_valid,
`ifdef RDI_RX_PARITY_EN
  input  logic              pl_parity,
  output logic              parity_err_o,
`endif
  output logic              lp_crd_valid_o,
  output logic [CNT_W-1:0]  lp_crd_cnt_o,
  output logic [DATA_W-1:0] data_out,
  output logic              is_valid_out,
  input  logic              is_on_off_in,
  input  logic              is_allocatable_in,
  output logic [CNT_W-1:0]  fill_o,
  output logic              overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  rx_state_e         state;
  rx_state_e         state_next;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              active;
  logic              buf_empty;
  logic              buf_full;
  logic              pop_now;
  logic              push_ok;
  logic              drop;

  // Push/pop qualification; at full a push survives only alongside a pop.
  always_comb begin
    active    = (state == RUN) || (state == DRAIN);
    buf_empty = (fill_o == '0);
    buf_full  = (fill_o == CNT_W'(DEPTH));
    pop_now   = active && !buf_empty && is_on_off_in && is_allocatable_in;
    push_ok   = pl_valid && active && (!buf_full || pop_now);
    drop      = pl_valid && !push_ok;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN waits until the last buffered word has left.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable_i) state_next = INIT;
      INIT:    state_next = RUN;
      RUN:     if (!enable_i) state_next = DRAIN;
      DRAIN: begin
        if (enable_i) begin
          state_next = RUN;
        end else if (buf_empty && !pop_now) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Buffer storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= pl_data;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_o     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_now) rd_ptr <= rd_ptr + PTR_W'(1);
      fill_o <= fill_o + CNT_W'(push_ok) - CNT_W'(pop_now);
      if (drop) overflow_o <= 1'b1;
    end
  end

  // DLA output register: one-cycle valid per popped word, data held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_out     <= '0;
      is_valid_out <= 1'b0;
    end else begin
      is_valid_out <= pop_now;
      if (pop_now) data_out <= mem[rd_ptr];
    end
  end

`ifdef RDI_RX_PARITY_EN
  // Even-parity check on accepted words; a bad word is still delivered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_err_o <= 1'b0;
    end else if (push_ok && ((^pl_data) != pl_parity)) begin
      parity_err_o <= 1'b1;
    end
  end
`endif

  rx_credit_ctrl #(
    .DEPTH     (DEPTH),
    .CRD_BATCH (CRD_BATCH),
    .CNT_W     (CNT_W)
  ) u_credit (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .state          (state),
    .pop            (pop_now),
    .buf_empty      (buf_empty),
    .lp_crd_valid_o (lp_crd_valid_o),
    .lp_crd_cnt_o   (lp_crd_cnt_o)
  );

endmodule

// File: tb/tb_rdi_rx_adapter.sv
// Directed self-checking bench for rdi_rx_adapter (DEPTH=16, CRD_BATCH=4).
module tb_rdi_rx_adapter;
  import adapter_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        enable_i;
  logic [63:0] pl_data;
  logic        pl_valid;
  logic        lp_crd_valid_o;
  logic [4:0]  lp_crd_cnt_o;
  logic [63:0] data_out;
  logic        is_valid_out;
  logic        is_on_off_in;
  logic        is_allocatable_in;
  logic [4:0]  fill_o;
  logic        overflow_o;
`ifdef RDI_RX_PARITY_EN
  logic        pl_parity;
  logic        parity_err_o;
  assign pl_parity = ^pl_data;
`endif

  int          errors;
  int          checks;
  int          words;
  int          pulses;
  int          consec;
  logic        prev_crd;
  logic [63:0] exp_word;

  rdi_rx_adapter dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .enable_i          (enable_i),
    .pl_data           (pl_data),
    .pl_valid          (pl_valid),
`ifdef RDI_RX_PARITY_EN
    .pl_parity         (pl_parity),
    .parity_err_o      (parity_err_o),
`endif
    .lp_crd_valid_o    (lp_crd_valid_o),
    .lp_crd_cnt_o      (lp_crd_cnt_o),
    .data_out          (data_out),
    .is_valid_out      (is_valid_out),
    .is_on_off_in      (is_on_off_in),
    .is_allocatable_in (is_allocatable_in),
    .fill_o            (fill_o),
    .overflow_o        (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, then sample just after the next rising edge.
  task automatic applyStimulus(input logic en, input logic vld, input logic [63:0] data,
                               input logic on, input logic alloc);
    enable_i          = en;
    pl_valid          = vld;
    pl_data           = data;
    is_on_off_in      = on;
    is_allocatable_in = alloc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_i  = 1'b1;
    applyStimulus(0, 0, 64'h0, 0, 0);
    applyStimulus(0, 0, 64'h0, 0, 0);
    rst_i  = 1'b0;

    // T1: reset values, then enable -> INIT -> RUN with a full advertisement
    checkOutput("rst state", 64'(dut.state), 64'(IDLE));
    checkOutput("rst fill", fill_o, 0);
    checkOutput("rst overflow", overflow_o, 0);
    checkOutput("rst valid", is_valid_out, 0);
    checkOutput("rst data", data_out, 0);
    checkOutput("rst crd valid", lp_crd_valid_o, 0);
    checkOutput("rst crd cnt", lp_crd_cnt_o, 0);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t1 state init", 64'(dut.state), 64'(INIT));
    checkOutput("t1 crd in init", lp_crd_valid_o, 0);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t1 state run", 64'(dut.state), 64'(RUN));
    checkOutput("t1 init crd valid", lp_crd_valid_o, 1);
    checkOutput("t1 init crd cnt", lp_crd_cnt_o, 16);
    checkOutput("t1 valid", is_valid_out, 0);
    checkOutput("t1 fill", fill_o, 0);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t1 crd one cycle", lp_crd_valid_o, 0);

    // T2: four back-to-back words with the DLA on
    applyStimulus(1, 1, 64'hA0, 1, 1);
    checkOutput("t2 latency", is_valid_out, 0);
    checkOutput("t2 fill", fill_o, 1);
    applyStimulus(1, 1, 64'hA1, 1, 1);
    checkOutput("t2 v0", is_valid_out, 1);
    checkOutput("t2 d0", data_out, 64'hA0);
    applyStimulus(1, 1, 64'hA2, 1, 1);
    checkOutput("t2 d1", data_out, 64'hA1);
    applyStimulus(1, 1, 64'hA3, 1, 1);
    checkOutput("t2 d2", data_out, 64'hA2);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t2 v3", is_valid_out, 1);
    checkOutput("t2 d3", data_out, 64'hA3);
    checkOutput("t2 fill empty", fill_o, 0);
    checkOutput("t2 crd early", lp_crd_valid_o, 0);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t2 valid off", is_valid_out, 0);
    checkOutput("t2 data hold", data_out, 64'hA3);
    checkOutput("t2 crd valid", lp_crd_valid_o, 1);
    checkOutput("t2 crd cnt", lp_crd_cnt_o, 4);
    applyStimulus(1, 0, 64'h0, 1, 1);
    checkOutput("t2 crd off", lp_crd_valid_o, 0);

    // T3: DLA off, 17 pushes -> full plus one drop; then drain
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 64'hB00 + 64'(i), 0, 0);
    checkOutput("t3 fill full", fill_o, 16);
    checkOutput("t3 no overflow yet", overflow_o, 0);
    applyStimulus(1, 1, 64'hB10, 0, 0);
    checkOutput("t3 fill stays", fill_o, 16);
    checkOutput("t3 overflow", overflow_o, 1);
    applyStimulus(1, 0, 64'h0, 1, 0);
    checkOutput("t3 no alloc no pop", is_valid_out, 0);
    checkOutput("t3 no alloc fill", fill_o, 16);
    exp_word = 64'hB00; words = 0; pulses = 0; consec = 0; prev_crd = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1, 0, 64'h0, 1, 1);
      if (is_valid_out) begin
        checkOutput("t3 data", data_out, exp_word);
        exp_word = exp_word + 64'd1;
        words++;
      end
      if (lp_crd_valid_o) begin
        checkOutput("t3 crd cnt", lp_crd_cnt_o, 4);
        pulses++;
        if (prev_crd) consec++;
      end
      prev_crd = lp_crd_valid_o;
    end
    checkOutput("t3 words", 64'(words), 16);
    checkOutput("t3 returns", 64'(pulses), 4);
    checkOutput("t3 back to back", 64'(consec), 0);
    checkOutput("t3 fill drained", fill_o, 0);
    checkOutput("t3 overflow sticky", overflow_o, 1);

    // T4: single word flushes a partial batch once the buffer is empty
    applyStimulus(1, 1, 64'hC5, 1, 1);
    words = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 64'h0, 1, 1);
      if (is_valid_out) begin
        checkOutput("t4 data", data_out, 64'hC5);
        words++;
      end
      if (lp_crd_valid_o) begin
        checkOutput("t4 crd cnt", lp_crd_cnt_o, 1);
        checkOutput("t4 fill at return", fill_o, 0);
        pulses++;
      end
    end
    checkOutput("t4 words", 64'(words), 1);
    checkOutput("t4 returns", 64'(pulses), 1);

    // T5: disable with 3 buffered words -> drain uncredited -> IDLE -> re-enable
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 64'hD0 + 64'(i), 0, 0);
    checkOutput("t5 fill", fill_o, 3);
    applyStimulus(0, 0, 64'h0, 0, 0);
    checkOutput("t5 state drain", 64'(dut.state), 64'(DRAIN));
    exp_word = 64'hD0; words = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 64'h0, 1, 1);
      if (is_valid_out) begin
        checkOutput("t5 data", data_out, exp_word);
        exp_word = exp_word + 64'd1;
        words++;
      end
      if (lp_crd_valid_o) pulses++;
    end
    checkOutput("t5 words", 64'(words), 3);
    checkOutput("t5 no returns", 64'(pulses), 0);
    checkOutput("t5 state idle", 64'(dut.state), 64'(IDLE));
    checkOutput("t5 fill", fill_o, 0);
    applyStimulus(1, 0, 64'h0, 0, 0);
    checkOutput("t5 state init", 64'(dut.state), 64'(INIT));
    applyStimulus(1, 0, 64'h0, 0, 0);
    checkOutput("t5 reinit crd valid", lp_crd_valid_o, 1);
    checkOutput("t5 reinit crd cnt", lp_crd_cnt_o, 16);

    // T6: reset with 5 words buffered
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 64'hF0 + 64'(i), 0, 0);
    checkOutput("t6 fill", fill_o, 5);
    rst_i = 1'b1;
    applyStimulus(1, 0, 64'h0, 0, 0);
    rst_i = 1'b0;
    checkOutput("t6 fill", fill_o, 0);
    checkOutput("t6 overflow", overflow_o, 0);
    checkOutput("t6 valid", is_valid_out, 0);
    checkOutput("t6 data", data_out, 0);
    checkOutput("t6 crd valid", lp_crd_valid_o, 0);
    checkOutput("t6 state", 64'(dut.state), 64'(IDLE));

    // T7: push and pop together at full -> both complete, no overflow
    applyStimulus(1, 0, 64'h0, 0, 0);
    applyStimulus(1, 0, 64'h0, 0, 0);
    checkOutput("t7 init crd cnt", lp_crd_cnt_o, 16);
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 64'hE00 + 64'(i), 0, 0);
    checkOutput("t7 fill full", fill_o, 16);
    applyStimulus(1, 1, 64'hE10, 1, 1);
    checkOutput("t7 fill stays", fill_o, 16);
    checkOutput("t7 no overflow", overflow_o, 0);
    checkOutput("t7 valid", is_valid_out, 1);
    checkOutput("t7 data", data_out, 64'hE00);

    // T8: a word arriving in IDLE is dropped and flagged
    rst_i = 1'b1;
    applyStimulus(0, 0, 64'h0, 0, 0);
    rst_i = 1'b0;
    applyStimulus(0, 1, 64'h55, 0, 0);
    checkOutput("t8 idle overflow", overflow_o, 1);
    checkOutput("t8 idle fill", fill_o, 0);
    checkOutput("t8 state", 64'(dut.state), 64'(IDLE));
`ifdef RDI_RX_PARITY_EN
    checkOutput("parity clean", parity_err_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
